// File: rtl/se_sram_fifo_srw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : se_sram_fifo_srw_pkg
// Purpose  : Shared types and constants for the SRAM-backed FIFO controller.
//            - t_sram_fifo_grant : who owned the single SRAM port last time
//                                  it was contended (write or read).
//            - obuf_depth        : entries in the output buffer that hides the
//                                  SRAM read latency.
//            - read_credit_ok()  : true while the output buffer can still
//                                  absorb one more read result.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package se_sram_fifo_srw_pkg;

  typedef enum logic {
    grant_write = 1'b0,
    grant_read  = 1'b1
  } t_sram_fifo_grant;

  localparam int unsigned obuf_depth = 2;

  // A read may only be launched if its result is guaranteed a slot in the
  // output buffer. A pop in the current cycle deliberately earns no credit:
  // that keeps the read request independent of pop_ready.
  function automatic logic read_credit_ok(input logic [1:0] obuf_count,
                                          input logic       rd_inflight);
    logic [2:0] committed;
    committed = {1'b0, obuf_count} + {2'b00, rd_inflight};
    return committed < 3'(obuf_depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/se_fifo_skid_2.sv
`default_nettype none
// ============================================================================
// Module   : se_fifo_skid_2
// Purpose  : Two-entry in-order output buffer sitting behind the SRAM read
//            port. Captures read results at its tail and presents the oldest
//            entry at its head.
// Ports    : clk_i          - clock
//            rst_i          - synchronous active-high reset (empties buffer)
//            en_i           - clock enable; when low nothing changes
//            capture_i      - write capture_data_i at the tail this cycle
//            capture_data_i - data to capture
//            pop_i          - remove the head this cycle (only when count!=0)
//            count_o        - number of entries held (0..2)
//            head_o         - oldest entry
// Revision : 1.0 - initial release
// ============================================================================
module se_fifo_skid_2 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  capture_i,
  input  logic [DATA_WIDTH-1:0] capture_data_i,
  input  logic                  pop_i,
  output logic [1:0]            count_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  logic [DATA_WIDTH-1:0] entry0_q, entry0_d;  // head
  logic [DATA_WIDTH-1:0] entry1_q, entry1_d;  // second oldest
  logic [1:0]            count_q,  count_d;

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    if (en_i) begin
      unique case ({capture_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) begin
            entry0_d = capture_data_i;
          end else begin
            entry1_d = capture_data_i;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          entry0_d = entry1_q;
          count_d  = count_q - 2'd1;
        end
        2'b11: begin
          // Head leaves while a new entry arrives: shift and append so the
          // count is unchanged and order is preserved.
          if (count_q == 2'd1) begin
            entry0_d = capture_data_i;
          end else begin
            entry0_d = entry1_q;
            entry1_d = capture_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // Data storage needs no reset: count_q alone decides what is valid.
  always_ff @(posedge clk_i) begin
    entry0_q <= entry0_d;
    entry1_q <= entry1_d;
  end

  assign count_o = count_q;
  assign head_o  = entry0_q;

endmodule
`default_nettype wire

// File: rtl/se_sram_fifo_srw.sv
`default_nettype none
// ============================================================================
// Module   : se_sram_fifo_srw
// Purpose  : FIFO controller fronting a single-port synchronous SRAM with a
//            registered read port (data valid the cycle after the select).
//            Push stream -> SRAM writes, SRAM reads -> pop stream through a
//            2-entry output buffer. The single SRAM port is shared between
//            pushes and refill reads with alternating priority.
// Ports    : sram_clock          - clock shared with the SRAM
//            sram_clock__enable  - clock enable; low freezes all state
//            reset               - synchronous active-high reset
//            push_valid/ready/data  - enqueue handshake
//            pop_valid/ready/data   - dequeue handshake (head of FIFO)
//            fifo_count          - entries held (SRAM + in flight + buffer)
//            sram_select         - SRAM access this cycle
//            sram_read_not_write - 1 read, 0 write
//            sram_address        - rd_ptr on read, wr_ptr on write
//            sram_write_data     - push_data
//            sram_data_out       - SRAM registered read data
// Revision : 1.0 - initial release
// ============================================================================
module se_sram_fifo_srw
  import se_sram_fifo_srw_pkg::*;
#(
  parameter int address_width = 10,
  parameter int data_width    = 8
) (
  input  logic                     sram_clock,
  input  logic                     sram_clock__enable,
  input  logic                     reset,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [data_width-1:0]    push_data,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [data_width-1:0]    pop_data,
  output logic [address_width+1:0] fifo_count,
  output logic                     sram_select,
  output logic                     sram_read_not_write,
  output logic [address_width-1:0] sram_address,
  output logic [data_width-1:0]    sram_write_data,
  input  logic [data_width-1:0]    sram_data_out
);

  localparam int unsigned SRAM_DEPTH = 1 << address_width;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [address_width-1:0] wr_ptr_q,      wr_ptr_d;
  logic [address_width-1:0] rd_ptr_q,      rd_ptr_d;
  logic [address_width:0]   sram_count_q,  sram_count_d;
  logic                     rd_inflight_q, rd_inflight_d;
  t_sram_fifo_grant         last_grant_q,  last_grant_d;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic [1:0] obuf_count;
  logic       sram_full;
  logic       read_req;
  logic       push_fire;
  logic       pop_fire;
  logic       do_write;
  logic       do_read;

  assign sram_full = (sram_count_q == (address_width+1)'(SRAM_DEPTH));

  always_comb begin
    read_req = (sram_count_q != '0) && read_credit_ok(obuf_count, rd_inflight_q);

    // A refill that lost the previous contention wins this one, so push_ready
    // is withdrawn for one cycle. push_valid is never looked at here.
    push_ready = !reset && !sram_full &&
                 !(read_req && (last_grant_q == grant_write));

    push_fire = push_valid && push_ready && sram_clock__enable;
    do_write  = push_fire;
    do_read   = read_req && !do_write && sram_clock__enable && !reset;

    pop_valid = !reset && (obuf_count != 2'd0);
    pop_fire  = pop_valid && pop_ready && sram_clock__enable;
  end

  // --------------------------------------------------------------------------
  // Next-state
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    sram_count_d  = sram_count_q;
    last_grant_d  = last_grant_q;
    rd_inflight_d = do_read;

    if (do_write) begin
      wr_ptr_d     = wr_ptr_q + address_width'(1);
      last_grant_d = grant_write;
    end
    if (do_read) begin
      rd_ptr_d     = rd_ptr_q + address_width'(1);
      last_grant_d = grant_read;
    end

    unique case ({do_write, do_read})
      2'b10:   sram_count_d = sram_count_q + (address_width+1)'(1);
      2'b01:   sram_count_d = sram_count_q - (address_width+1)'(1);
      default: sram_count_d = sram_count_q;
    endcase
  end

  always_ff @(posedge sram_clock) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      sram_count_q  <= '0;
      rd_inflight_q <= 1'b0;
      last_grant_q  <= grant_write;
    end else if (sram_clock__enable) begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      sram_count_q  <= sram_count_d;
      rd_inflight_q <= rd_inflight_d;
      last_grant_q  <= last_grant_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output buffer. rd_inflight_q marks the cycle in which the SRAM presents
  // the data read one cycle earlier; reset overrides it, so a read that was
  // in flight when reset arrived is dropped.
  // --------------------------------------------------------------------------
  se_fifo_skid_2 #(
    .DATA_WIDTH (data_width)
  ) u_obuf (
    .clk_i          (sram_clock),
    .rst_i          (reset),
    .en_i           (sram_clock__enable),
    .capture_i      (rd_inflight_q),
    .capture_data_i (sram_data_out),
    .pop_i          (pop_fire),
    .count_o        (obuf_count),
    .head_o         (pop_data)
  );

  // --------------------------------------------------------------------------
  // SRAM drive and occupancy
  // --------------------------------------------------------------------------
  assign sram_select         = do_write || do_read;
  assign sram_read_not_write = do_read;
  assign sram_address        = do_read ? rd_ptr_q : wr_ptr_q;
  assign sram_write_data     = push_data;

  assign fifo_count = {1'b0, sram_count_q}
                    + (address_width+2)'(obuf_count)
                    + (address_width+2)'(rd_inflight_q);

endmodule
`default_nettype wire

// File: tb/tb_se_sram_fifo_srw.sv
`default_nettype none
// ============================================================================
// Module   : tb_se_sram_fifo_srw
// Purpose  : Self-checking bench for se_sram_fifo_srw paired with a
//            behavioural single-port registered-read SRAM. A negedge monitor
//            keeps an ordered queue of accepted entries as the reference
//            FIFO and checks every pop, the occupancy and the handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_se_sram_fifo_srw;

  localparam int AW  = 3;
  localparam int DW  = 8;
  localparam int CAP = (1 << AW) + 2;

  logic          clk        = 1'b0;
  logic          en         = 1'b1;
  logic          rst        = 1'b1;
  logic          push_valid = 1'b0;
  logic          pop_ready  = 1'b0;
  logic [DW-1:0] push_data  = '0;
  logic          push_ready;
  logic          pop_valid;
  logic [DW-1:0] pop_data;
  logic [AW+1:0] fifo_count;
  logic          sram_select;
  logic          sram_rnw;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = 8'h5A;

  always #5 clk = ~clk;

  se_sram_fifo_srw #(
    .address_width (AW),
    .data_width    (DW)
  ) dut (
    .sram_clock          (clk),
    .sram_clock__enable  (en),
    .reset               (rst),
    .push_valid          (push_valid),
    .push_ready          (push_ready),
    .push_data           (push_data),
    .pop_valid           (pop_valid),
    .pop_ready           (pop_ready),
    .pop_data            (pop_data),
    .fifo_count          (fifo_count),
    .sram_select         (sram_select),
    .sram_read_not_write (sram_rnw),
    .sram_address        (sram_addr),
    .sram_write_data     (sram_wdata),
    .sram_data_out       (sram_rdata)
  );

  // Behavioural SRAM: one access per enabled cycle, registered read data.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (en && sram_select) begin
      if (sram_rnw) sram_rdata <= mem[sram_addr];
      else          mem[sram_addr] <= sram_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard state
  // --------------------------------------------------------------------------
  logic [DW-1:0] sb[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc   = 0;
  int  n_push = 0;
  int  rise_cyc = -1;
  logic pv_prev = 1'b0;
  logic [DW-1:0] last_pop = '0;
  bit  streaming = 1'b0;
  int  pr_low_streak = 0, pr_low_max = 0;
  logic prev_read = 1'b0;
  int  rr_viol = 0;
  int  starve = 0, starve_max = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // --------------------------------------------------------------------------
  // Monitor: samples at negedge, i.e. the values that the next posedge acts on.
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst) begin
      check("reset_push_ready", longint'(push_ready), 0);
      check("reset_pop_valid", longint'(pop_valid), 0);
      check("reset_sram_select", longint'(sram_select), 0);
      sb.delete();
      pv_prev = 1'b0;
      starve = 0;
      prev_read = 1'b0;
      pr_low_streak = 0;
    end else begin
      check("fifo_count", longint'(fifo_count), longint'(sb.size()));
      if (sb.size() == 0) check("pop_valid_when_empty", longint'(pop_valid), 0);
      if (sb.size() == CAP) check("push_ready_when_full", longint'(push_ready), 0);
      if (!en) check("sram_select_when_disabled", longint'(sram_select), 0);

      if (pop_valid && !pv_prev && rise_cyc < 0) rise_cyc = cyc;
      pv_prev = pop_valid;

      if (en) begin
        starve = (sb.size() != 0 && !pop_valid) ? starve + 1 : 0;
        if (starve > starve_max) starve_max = starve;

        if (streaming && push_valid && sb.size() < (1 << AW)) begin
          pr_low_streak = push_ready ? 0 : pr_low_streak + 1;
          if (pr_low_streak > pr_low_max) pr_low_max = pr_low_streak;
          if (prev_read && sram_select && sram_rnw) rr_viol++;
        end
        prev_read = sram_select && sram_rnw;

        if (pop_valid && pop_ready) begin
          if (sb.size() == 0) begin
            check("pop_underflow", 1, 0);
          end else begin
            logic [DW-1:0] exp_d;
            exp_d = sb.pop_front();
            check("pop_data", longint'(pop_data), longint'(exp_d));
            last_pop = pop_data;
          end
        end
        if (push_valid && push_ready) begin
          sb.push_back(push_data);
          n_push++;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic push_word(input logic [DW-1:0] d, output int fire_cyc);
    push_valid = 1'b1;
    push_data  = d;
    fire_cyc   = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (push_ready && en) fire_cyc = cyc;
      @(posedge clk); #1;
      if (fire_cyc >= 0) break;
    end
    push_valid = 1'b0;
    if (fire_cyc < 0) check("push_accept_timeout", 0, 1);
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    for (int t = 0; t < 300; t++) begin
      if (sb.size() == 0 && fifo_count == 0 && !pop_valid) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check({name, "_drain_done"}, longint'(done), 1);
    check({name, "_drain_count"}, longint'(fifo_count), 0);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int f;
    int f1;
    int target;
    int budget;
    bit en_done;
    bit found;
    logic [AW+1:0] c0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_count", longint'(fifo_count), 0);
    @(posedge clk); #1;

    // Latency and ordering of three back-to-back pushes
    pop_ready = 1'b0;
    rise_cyc  = -1;
    push_word(8'h11, f1);
    push_word(8'h22, f);
    push_word(8'h33, f);
    repeat (6) @(posedge clk);
    #1;
    check("first_pop_latency", longint'(rise_cyc - f1), 3);
    check("three_entry_count", longint'(fifo_count), 3);
    check("head_is_0x11", longint'(pop_data), 8'h11);
    drain("three");
    check("three_last_pop", longint'(last_pop), 8'h33);

    // Fill to capacity, then empty (pointers wrap)
    pop_ready = 1'b0;
    for (int i = 0; i < CAP; i++) push_word(8'(i * 17 + 3), f);
    push_valid = 1'b1;
    push_data  = 8'hEE;
    repeat (5) @(posedge clk);
    #1;
    check("full_count", longint'(fifo_count), CAP);
    check("full_push_ready", longint'(push_ready), 0);
    push_valid = 1'b0;
    drain("full");

    // Continuous push and pop streaming
    pop_ready = 1'b1;
    streaming = 1'b1;
    for (int i = 0; i < 200; i++) push_word(8'($urandom), f);
    streaming = 1'b0;
    drain("stream");
    check("stream_push_ready_low_run", longint'(pr_low_max <= 1), 1);
    check("stream_back_to_back_reads", longint'(rr_viol), 0);

    // Random traffic with a three-cycle enable gap in the middle
    target  = n_push + 5000;
    budget  = 0;
    en_done = 1'b0;
    while (n_push < target && budget < 40000) begin
      if (!en_done && n_push >= target - 2500) begin
        push_valid = 1'b1;
        pop_ready  = 1'b1;
        push_data  = 8'($urandom);
        c0 = fifo_count;
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("enable_low_count_hold", longint'(fifo_count), longint'(c0));
        en = 1'b1;
        en_done = 1'b1;
      end
      push_valid = 1'($urandom % 2);
      pop_ready  = 1'($urandom % 2);
      push_data  = 8'($urandom);
      @(posedge clk); #1;
      budget++;
    end
    check("random_push_budget", longint'(n_push >= target), 1);
    check("enable_gap_exercised", longint'(en_done), 1);
    drain("random");
    check("read_starvation_bound", longint'(starve_max <= 4), 1);

    // Reset with entries stored and a read in flight
    pop_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(8'(8'h60 + i), f);
    repeat (8) @(posedge clk);
    #1 pop_ready = 1'b1;
    @(posedge clk);
    #1 pop_ready = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (sram_select && sram_rnw && en) found = 1'b1;
      @(posedge clk); #1;
      if (found) break;
    end
    check("read_issued_before_reset", longint'(found), 1);
    check("entries_before_reset", longint'(fifo_count), 5);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("after_reset_pop_valid", longint'(pop_valid), 0);
    check("after_reset_count", longint'(fifo_count), 0);
    repeat (4) @(posedge clk);
    #1;
    check("stale_read_not_captured", longint'(fifo_count), 0);
    push_word(8'hA5, f);
    drain("after_reset");
    check("a5_popped", longint'(last_pop), 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
